// File: rtl/rf_dbg_defs.sv
//==============================================================================
// Module      : rf_dbg_defs (package)
// Description : Shared command-op and FSM state encodings for the register-file
//               debug accessor and the debug transport bridge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_dbg_defs;

    // Command opcodes carried on cmd_op
    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } dbg_op_e;

    // Accessor FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_HALT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } dbg_state_e;

    // Highest architectural register index; a dump stops here
    localparam logic [4:0] c_LAST_REG = 5'd31;

    // The reserved opcode behaves exactly like a read
    function automatic dbg_op_e norm_op(input logic [1:0] op);
        dbg_op_e w_op;
        w_op = dbg_op_e'(op);
        return (w_op == OP_RSVD) ? OP_READ : w_op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_debug_access.sv
//==============================================================================
// Module      : rf_debug_access
// Description : Debug-side accessor of the integer register file. Accepts
//               READ / WRITE / DUMP commands, halts the core, drives the
//               register-file ports and streams back response beats.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_debug_access
    import rf_dbg_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    // command channel
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [4:0]      cmd_addr,
    input  logic [XLEN-1:0] cmd_wdata,
    // response stream
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [4:0]      rsp_addr,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_last,
    // core halt handshake
    output logic            halt_req,
    input  logic            core_halted,
    // register-file ports
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    // status
    output logic            busy
);

    dbg_state_e r_state;
    dbg_op_e    r_op;

    dbg_op_e    w_cmd_op;
    logic [4:0] w_cmd_addr;
    logic       w_dump_more;

    assign w_cmd_op    = norm_op(cmd_op);
    assign w_cmd_addr  = (w_cmd_op == OP_DUMP) ? 5'd0 : cmd_addr;
    assign w_dump_more = (r_op == OP_DUMP) && (rf_raddr != c_LAST_REG);

    // The write strobe is qualified by the live core_halted so a core that
    // resumes during ACCESS can never see a debug write; x0 is never written.
    assign rf_we = (r_state == ST_ACCESS) && core_halted &&
                   (r_op == OP_WRITE) && (rf_waddr != 5'd0);

    assign busy = (r_state != ST_IDLE);

    // Command FSM; rf_raddr doubles as the latched/dump-walking register index
    // and rf_wdata as the latched write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_READ;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_addr  <= 5'd0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            halt_req  <= 1'b0;
            rf_raddr  <= 5'd0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_op      <= w_cmd_op;
                        rf_raddr  <= w_cmd_addr;
                        rf_waddr  <= w_cmd_addr;
                        rf_wdata  <= cmd_wdata;
                        cmd_ready <= 1'b0;
                        halt_req  <= 1'b1;
                        r_state   <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (core_halted) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!core_halted) begin
                        r_state <= ST_HALT;
                    end else begin
                        rsp_addr  <= rf_raddr;
                        if (r_op == OP_WRITE) begin
                            rsp_data <= (rf_raddr == 5'd0) ? '0 : rf_wdata;
                        end else begin
                            rsp_data <= rf_rdata;
                        end
                        rsp_last  <= (r_op != OP_DUMP) || (rf_raddr == c_LAST_REG);
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (w_dump_more) begin
                            rf_raddr <= rf_raddr + 5'd1;
                            r_state  <= ST_ACCESS;
                        end else begin
                            halt_req  <= 1'b0;
                            cmd_ready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_debug_access.sv
//==============================================================================
// Module      : tb_rf_debug_access
// Description : Scoreboard bench for rf_debug_access with an external register
//               file model and a reference register image.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_debug_access;
    import rf_dbg_defs::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [4:0]      cmd_addr;
    logic [XLEN-1:0] cmd_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [4:0]      rsp_addr;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_last;
    logic            halt_req;
    logic            core_halted;
    logic [4:0]      rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            busy;

    rf_debug_access #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .halt_req    (halt_req),
        .core_halted (core_halted),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External register file: combinational read, x0 reads 0
    logic [XLEN-1:0] rf_mem [32];
    logic            pre_we;
    logic [4:0]      pre_addr;
    logic [XLEN-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we)     rf_mem[pre_addr] <= pre_data;
        else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = (rf_raddr == 5'd0) ? '0 : rf_mem[rf_raddr];

    // Reference model and scoreboard queues
    typedef struct { logic [4:0] addr; logic [XLEN-1:0] data; logic last; } beat_t;
    typedef struct { logic [4:0] addr; logic [XLEN-1:0] data; } wr_t;
    logic [XLEN-1:0] ref_regs [32];
    beat_t exp_q[$];
    wr_t   wr_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // rsp_ready driver: 0 = always ready, 1 = random, 2 = never ready
    int bp_mode = 0;
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 1) == 1);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expectations on every response handshake / write strobe
    logic            lat_armed = 1'b0;
    logic            first_pending;
    int              accept_cyc;
    logic            prev_stall, prev_valid;
    logic [4:0]      prev_addr;
    logic [XLEN-1:0] prev_data;
    logic            prev_last;
    beat_t           mon_b;
    wr_t             mon_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall    = 1'b0;
            prev_valid    = 1'b0;
            first_pending = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                accept_cyc    = cyc;
                first_pending = 1'b1;
            end
            check("halt_req_vs_busy", halt_req, busy);
            check("cmd_ready_vs_idle", cmd_ready, !busy);
            if (prev_stall) begin
                check("stall_valid", rsp_valid, 1'b1);
                check("stall_addr", rsp_addr, prev_addr);
                check("stall_data", rsp_data, prev_data);
                check("stall_last", rsp_last, prev_last);
            end
            if (rsp_valid && !prev_valid && first_pending) begin
                if (lat_armed) check("latency", cyc - accept_cyc, 3);
                first_pending = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_addr", rsp_addr, mon_b.addr);
                    check("beat_data", rsp_data, mon_b.data);
                    check("beat_last", rsp_last, mon_b.last);
                end
            end
            if (rf_we) begin
                check("we_while_halted", core_halted, 1'b1);
                if (wr_q.size() == 0) begin
                    fail_now("unexpected_rf_we");
                end else begin
                    mon_w = wr_q.pop_front();
                    check("we_addr", rf_waddr, mon_w.addr);
                    check("we_data", rf_wdata, mon_w.data);
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_valid = rsp_valid;
            prev_addr  = rsp_addr;
            prev_data  = rsp_data;
            prev_last  = rsp_last;
        end
    end

    // Load both the register file and the reference image
    task automatic preload_all(input logic dead5);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            pre_we   = 1'b1;
            pre_addr = 5'(i);
            pre_data = (dead5 && i == 5) ? 32'hDEADBEEF : 32'(i * 32'h11);
            ref_regs[i] = (i == 0) ? '0 : pre_data;
        end
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Issue one command and push what the spec says must come back
    task automatic send(input logic [1:0] op, input logic [4:0] addr, input logic [XLEN-1:0] wd);
        int t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 200);
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout");
        end else begin
            case (op)
                2'b01: begin
                    if (addr != 5'd0) begin
                        ref_regs[addr] = wd;
                        wr_q.push_back('{addr: addr, data: wd});
                    end
                    exp_q.push_back('{addr: addr, data: (addr == 5'd0) ? '0 : wd, last: 1'b1});
                end
                2'b10: begin
                    for (int i = 0; i < 32; i++)
                        exp_q.push_back('{addr: 5'(i), data: (i == 0) ? '0 : ref_regs[i], last: (i == 31)});
                end
                default: begin
                    exp_q.push_back('{addr: addr, data: (addr == 5'd0) ? '0 : ref_regs[addr], last: 1'b1});
                end
            endcase
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q.size() != 0) && t < 3000);
        if (busy || exp_q.size() != 0) fail_now("done_timeout");
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_addr    = 5'd0;
        cmd_wdata   = '0;
        core_halted = 1'b1;
        pre_we      = 1'b0;
        pre_addr    = 5'd0;
        pre_data    = '0;

        preload_all(1'b1);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_addr", rsp_addr, 5'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_last", rsp_last, 1'b0);
        check("rst_halt_req", halt_req, 1'b0);
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_rf_raddr", rf_raddr, 5'd0);
        check("rst_rf_waddr", rf_waddr, 5'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // READ x5 with core already halted
        lat_armed = 1'b1;
        send(2'b00, 5'd5, '0);
        wait_done();

        // WRITE x7, then read it back; reserved opcode acts as READ
        send(2'b01, 5'd7, 32'h12345678);
        wait_done();
        send(2'b00, 5'd7, '0);
        wait_done();
        send(2'b11, 5'd7, '0);
        wait_done();

        // WRITE to x0 never strobes rf_we, still answers with 0
        send(2'b01, 5'd0, 32'hFFFFFFFF);
        wait_done();
        send(2'b00, 5'd0, '0);
        wait_done();

        // DUMP under random backpressure
        preload_all(1'b0);
        bp_mode = 1;
        send(2'b10, 5'd13, '0);
        wait_done();
        bp_mode = 0;

        // Delayed halt, then halt dropped during ACCESS
        lat_armed   = 1'b0;
        core_halted = 1'b0;
        send(2'b01, 5'd9, 32'hA5A55A5A);
        repeat (10) begin
            @(negedge clk);
            check("halt_wait_no_valid", rsp_valid, 1'b0);
            check("halt_wait_no_we", rf_we, 1'b0);
        end
        @(posedge clk); #1; core_halted = 1'b1;
        @(posedge clk); #1; core_halted = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("halt_drop_no_valid", rsp_valid, 1'b0);
            check("halt_drop_no_we", rf_we, 1'b0);
        end
        @(posedge clk); #1; core_halted = 1'b1;
        wait_done();
        lat_armed = 1'b1;
        send(2'b00, 5'd9, '0);
        wait_done();

        // Randomized command mix
        for (int n = 0; n < 25; n++) begin
            bp_mode = int'($urandom_range(0, 1));
            send(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
            wait_done();
        end
        bp_mode = 0;

        // Reset while a DUMP beat is stalled in RESP
        bp_mode = 2;
        send(2'b10, 5'd0, '0);
        begin
            int t;
            t = 0;
            while (!rsp_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("dump_reached_resp", rsp_valid, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        @(posedge clk);
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check("rst_mid_halt_req", halt_req, 1'b0);
        check("rst_mid_cmd_ready", cmd_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        bp_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b00, 5'd3, '0);
        wait_done();

        check("exp_q_drained", exp_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
